// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debug_pkg
//  Description : Shared debug-side types and defaults: register-dump FSM
//                state encoding and default sizing constants.
//  Revision    : 1.0  initial release
// ============================================================================
package debug_pkg;

  // Register-dump controller states (3-bit encoding)
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    READ  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } dump_state_t;

  localparam int NREGS_DEFAULT        = 32;
  localparam int DRAIN_CYCLES_DEFAULT = 3;

endpackage : debug_pkg
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter
//  Description : Loadable down counter that saturates at zero and reports a
//                zero flag. Load has priority over enable.
//  Revision    : 1.0  initial release
// ============================================================================
module down_counter #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,       // synchronous, active-low
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Count register: load wins, otherwise decrement while enabled and nonzero
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule : down_counter
`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_ctrl
//  Description : Freezes the pipeline, waits for in-flight writebacks to
//                land, then borrows the register-file rs port and streams
//                every register (index 0 first) over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_dump_ctrl
  import debug_pkg::*;
#(
  parameter  int NBITS        = 32,
  parameter  int NREGS        = NREGS_DEFAULT,
  parameter  int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  localparam int IDXW         = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,       // synchronous, active-low
  input  logic             i_dump_req,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_dbg_sel,
  output logic [IDXW-1:0]  o_rs_sel,
  input  logic [NBITS-1:0] i_rs_data,
  output logic [NBITS-1:0] o_data,
  output logic [IDXW-1:0]  o_idx,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_done
);

  localparam int CNTW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  dump_state_t      r_state;
  dump_state_t      w_next;
  logic [IDXW-1:0]  r_idx;
  logic [IDXW-1:0]  r_idx_out;
  logic [NBITS-1:0] r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_stall;
  logic             r_done;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic             w_cnt_zero;
  logic             w_last;
  logic             w_accept;

  assign w_cnt_load = (r_state == IDLE) && i_dump_req;
  assign w_cnt_en   = (r_state == DRAIN);
  assign w_last     = (r_idx == IDXW'(NREGS - 1));
  assign w_accept   = (r_state == SEND) && i_ready;

  // Drain counter: loaded with DRAIN_CYCLES-1 so DRAIN lasts DRAIN_CYCLES cycles
  down_counter #(
    .WIDTH (CNTW)
  ) u_drain_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_cnt_load),
    .i_load_val (CNTW'(DRAIN_CYCLES - 1)),
    .i_en       (w_cnt_en),
    .o_zero     (w_cnt_zero)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic plus the decoded rs-port takeover outputs
  always_comb begin
    w_next    = r_state;
    o_dbg_sel = 1'b0;
    o_rs_sel  = '0;
    case (r_state)
      IDLE:  if (i_dump_req) w_next = DRAIN;
      DRAIN: if (w_cnt_zero) w_next = READ;
      READ: begin
        o_dbg_sel = 1'b1;
        o_rs_sel  = r_idx;
        w_next    = SEND;
      end
      SEND: begin
        o_dbg_sel = 1'b1;
        o_rs_sel  = r_idx;
        if (i_ready) w_next = w_last ? DONE : READ;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered datapath: index walk, captured beat, and status flags
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_idx     <= '0;
      r_idx_out <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_stall   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy  <= (w_next != IDLE);
      r_stall <= (w_next != IDLE);
      r_done  <= (w_next == DONE);
      if (w_cnt_load) begin
        r_idx <= '0;
      end
      if (r_state == READ) begin
        r_data    <= i_rs_data;
        r_idx_out <= r_idx;
        r_valid   <= 1'b1;
      end
      if (w_accept) begin
        r_valid <= 1'b0;
        if (!w_last) begin
          r_idx <= r_idx + IDXW'(1);
        end
      end
    end
  end

  assign o_busy  = r_busy;
  assign o_stall = r_stall;
  assign o_data  = r_data;
  assign o_idx   = r_idx_out;
  assign o_valid = r_valid;
  assign o_done  = r_done;

endmodule : regfile_dump_ctrl
`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_dump_ctrl
//  Description : Directed self-checking bench for regfile_dump_ctrl with a
//                behavioural 32x32 register file on the rs port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_dump_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_dump_req;
  logic        o_busy;
  logic        o_stall;
  logic        o_dbg_sel;
  logic [4:0]  o_rs_sel;
  logic [31:0] i_rs_data;
  logic [31:0] o_data;
  logic [4:0]  o_idx;
  logic        o_valid;
  logic        i_ready;
  logic        o_done;

  logic [31:0] rf [0:31];
  int          n_total;
  int          n_bad;

  assign i_rs_data = rf[o_rs_sel];

  regfile_dump_ctrl #(
    .NBITS        (32),
    .NREGS        (32),
    .DRAIN_CYCLES (3)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_dump_req (i_dump_req),
    .o_busy     (o_busy),
    .o_stall    (o_stall),
    .o_dbg_sel  (o_dbg_sel),
    .o_rs_sel   (o_rs_sel),
    .i_rs_data  (i_rs_data),
    .o_data     (o_data),
    .o_idx      (o_idx),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_done     (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_val(input int k, input bit wb);
    if (wb && k == 9) return 32'hDEADBEEF;
    return 32'hA5000000 + 32'(k);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  {31'd0, o_busy},    32'd0);
    check({tag, "_stall"}, {31'd0, o_stall},   32'd0);
    check({tag, "_valid"}, {31'd0, o_valid},   32'd0);
    check({tag, "_done"},  {31'd0, o_done},    32'd0);
    check({tag, "_dsel"},  {31'd0, o_dbg_sel}, 32'd0);
    check({tag, "_rssel"}, {27'd0, o_rs_sel},  32'd0);
    check({tag, "_idx"},   {27'd0, o_idx},     32'd0);
    check({tag, "_data"},  o_data,             32'd0);
  endtask

  // One dump from request to release. Optional: hold i_ready low on a beat,
  // re-request during a beat, inject a writeback to r9, or reset mid-beat.
  task automatic run_dump(input int stall_beat, input int stall_len, input int req_beat,
                          input int abort_beat, input bit wb, input int exp_busy);
    int beat, held, busy_cnt, done_cnt, last_acc, prev_first, cur;
    bit seen, fin, prev_done, aborted;
    beat = 0; held = 0; busy_cnt = 0; done_cnt = 0; last_acc = -10; prev_first = -10;
    seen = 0; fin = 0; prev_done = 0; aborted = 0;
    i_dump_req = 1'b1;
    i_ready    = 1'b1;
    @(negedge i_clk);
    for (int c = 1; c <= 400 && !fin; c++) begin
      i_dump_req = 1'b0;
      i_ready    = 1'b1;
      if (c == 1) begin
        check("stall_next", {31'd0, o_stall}, 32'd1);
        check("busy_next",  {31'd0, o_busy},  32'd1);
        if (wb) rf[9] = 32'hDEADBEEF;
      end
      if (prev_done) check("stall_drop", {31'd0, o_stall}, 32'd0);
      prev_done = o_done;
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        check("done_lat", 32'(c - last_acc), 32'd1);
      end
      if (o_valid) begin
        cur = beat;
        check("dbg_sel", {31'd0, o_dbg_sel}, 32'd1);
        check("rs_sel",  {27'd0, o_rs_sel},  32'(cur));
        if (!seen) begin
          seen = 1;
          if (cur == 0) check("first_lat", 32'(c), 32'd5);
          else check("beat_gap", 32'(c - prev_first),
                     (cur == stall_beat + 1) ? 32'(2 + stall_len) : 32'd2);
          prev_first = c;
          check("beat_idx",  {27'd0, o_idx}, 32'(cur));
          check("beat_data", o_data, exp_val(cur, wb));
        end
        if (cur == req_beat) i_dump_req = 1'b1;
        if (cur == abort_beat) begin
          i_rst   = 1'b0;
          i_ready = 1'b0;
          @(negedge i_clk);
          check("abort_valid", {31'd0, o_valid}, 32'd0);
          check("abort_stall", {31'd0, o_stall}, 32'd0);
          check("abort_busy",  {31'd0, o_busy},  32'd0);
          check("abort_done",  {31'd0, o_done},  32'd0);
          i_rst = 1'b1;
          for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            check("abort_nodone", {30'd0, o_done, o_busy}, 32'd0);
          end
          aborted = 1;
          fin     = 1;
        end else if (cur == stall_beat && held < stall_len) begin
          i_ready = 1'b0;
          held++;
          check("hold_data", o_data, exp_val(cur, wb));
          check("hold_idx",  {27'd0, o_idx}, 32'(cur));
        end else begin
          last_acc = c;
          beat++;
          seen = 0;
        end
      end
      if (!fin && !o_busy) fin = 1;
      if (!fin) @(negedge i_clk);
    end
    i_dump_req = 1'b0;
    i_ready    = 1'b1;
    if (!fin) check("timeout", 32'd1, 32'd0);
    if (!aborted) begin
      check("beat_count", 32'(beat),     32'd32);
      check("done_count", 32'(done_cnt), 32'd1);
      check("busy_total", 32'(busy_cnt), 32'(exp_busy));
    end
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    i_rst      = 1'b0;
    i_dump_req = 1'b0;
    i_ready    = 1'b0;
    for (int k = 0; k < 32; k++) rf[k] = 32'hA5000000 + 32'(k);

    // Reset held two cycles, then idle with no request
    @(negedge i_clk);
    @(negedge i_clk);
    check_quiet("reset");
    i_rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      check_quiet("idle");
    end

    // Full dump with ready always high
    run_dump(-1, 0, -1, -1, 1'b0, 68);
    @(negedge i_clk);

    // Backpressure: ready low 7 cycles on beat 5
    run_dump(5, 7, -1, -1, 1'b0, 75);
    @(negedge i_clk);

    // Writeback to r9 during drain
    run_dump(-1, 0, -1, -1, 1'b1, 68);
    rf[9] = 32'hA5000009;
    @(negedge i_clk);

    // Request while busy is ignored and not queued
    run_dump(-1, 0, 3, -1, 1'b0, 68);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("no_requeue", {31'd0, o_busy}, 32'd0);
    end

    // Reset during beat 12, then a fresh dump restarts at index 0
    run_dump(-1, 0, -1, 12, 1'b0, 0);
    run_dump(-1, 0, -1, -1, 1'b0, 68);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_regfile_dump_ctrl
`default_nettype wire
